// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU: one 1-bit slice per cycle (and/or/add/sub/slt/nor/nand), slt closed through the MSB set bit.
// Latency: start accepted at edge N, done pulses in the cycle after edge N+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy. Optional ALU_SERIAL_CMP_EN adds eq/lt compare outputs.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
`ifdef ALU_SERIAL_CMP_EN
    output logic             eq,
    output logic             lt,
`endif
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [3:0]       ctl_q;
    logic             set_q;

    logic             s1, s2, sum_bit, c_next, slice_bit, last;
    logic             ovf_v, set_v, supported, is_arith, is_slt, flags_en;
    logic [WIDTH-1:0] fin_sh, final_res;

    always_comb begin
        s1       = a_sh[0] ^ ctl_q[3];
        s2       = b_sh[0] ^ ctl_q[2];
        sum_bit  = s1 ^ s2 ^ carry;
        c_next   = (s1 & s2) | (s1 & carry) | (s2 & carry);
        case (ctl_q[1:0])
            2'b00:   slice_bit = s1 & s2;
            2'b01:   slice_bit = s1 | s2;
            2'b10:   slice_bit = sum_bit;
            default: slice_bit = 1'b0;
        endcase
        last     = (cnt == CW'(WIDTH - 1));
        fin_sh   = {slice_bit, res_sh};
        // At the MSB, carry holds the carry into the MSB and c_next the carry out.
        ovf_v    = carry ^ c_next;
        set_v    = sum_bit ^ ovf_v;
        is_arith = (ctl_q == 4'b0010) || (ctl_q == 4'b0110);
        is_slt   = (ctl_q == 4'b0111);
        supported = is_arith || is_slt || (ctl_q == 4'b0000) || (ctl_q == 4'b0001)
                 || (ctl_q == 4'b1100) || (ctl_q == 4'b1101);
`ifdef ALU_SERIAL_CMP_EN
        flags_en = is_arith || is_slt;
`else
        flags_en = is_arith;
`endif
        if (!supported)
            final_res = '0;
        else if (is_slt)
            final_res = {{(WIDTH-1){1'b0}}, set_v};
        else
            final_res = fin_sh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            ctl_q    <= '0;
            set_q    <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh   <= src1;
                        b_sh   <= src2;
                        ctl_q  <= ALU_control;
                        carry  <= ALU_control[2];
                        cnt    <= '0;
                        res_sh <= '0;
                        busy   <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= fin_sh[WIDTH-1:1];
                    carry  <= c_next;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        state    <= S_FIN;
                        done     <= 1'b1;
                        result   <= final_res;
                        zero     <= (final_res == '0);
                        cout     <= flags_en ? c_next : 1'b0;
                        overflow <= flags_en ? ovf_v : 1'b0;
                        set_q    <= set_v;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_SERIAL_CMP_EN
    assign eq = zero && (ctl_q == 4'b0110);
    assign lt = set_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed vectors for alu_serial_ctrl with hand-computed expectations.
module tb_alu_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] src1, src2, result;
    logic [3:0]  ALU_control;
    logic        zero, cout, overflow, busy, done;
`ifdef ALU_SERIAL_CMP_EN
    logic        eq, lt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .src1(src1), .src2(src2),
        .ALU_control(ALU_control), .result(result), .zero(zero), .cout(cout),
        .overflow(overflow), .busy(busy),
`ifdef ALU_SERIAL_CMP_EN
        .eq(eq), .lt(lt),
`endif
        .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns cycles counted from the accepting edge to the first edge after which done is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input bit hold, output int cyc);
        @(negedge clk);
        src1 = a; src2 = b; ALU_control = c; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic op_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] e_res, input logic e_zero,
                          input logic e_cout, input logic e_ovf);
        int cyc;
        do_op(a, b, c, 1'b0, cyc);
        chk({tag, ".lat"}, cyc, 33);
        chk({tag, ".res"}, result, e_res);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
        chk({tag, ".cout"}, {31'd0, cout}, {31'd0, e_cout});
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e_ovf});
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        logic slt_c1, slt_v1, slt_c2, slt_v2;
`ifdef ALU_SERIAL_CMP_EN
        slt_c1 = 1'b1; slt_v1 = 1'b1; slt_c2 = 1'b0; slt_v2 = 1'b1;
`else
        slt_c1 = 1'b0; slt_v1 = 1'b0; slt_c2 = 1'b0; slt_v2 = 1'b0;
`endif
        rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; ALU_control = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.res", result, 32'd0);
        chk("rst.zero", {31'd0, zero}, 32'd1);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.cout", {31'd0, cout}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk); rst = 1'b0;

        op_chk("add_ovf",  32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 0, 0, 1);
        op_chk("sub_eq",   32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1, 1, 0);
`ifdef ALU_SERIAL_CMP_EN
        chk("sub_eq.eq", {31'd0, eq}, 32'd1);
`endif
        op_chk("slt_neg",  32'h80000000, 32'h00000001, 4'b0111, 32'h00000001, 0, slt_c1, slt_v1);
        op_chk("slt_ovf",  32'h7FFFFFFF, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1, slt_c2, slt_v2);
        op_chk("nor",      32'hF0F0F0F0, 32'h0F0F0000, 4'b1100, 32'h00000F0F, 0, 0, 0);
        op_chk("nand",     32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1101, 32'h00000000, 1, 0, 0);
        op_chk("and",      32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 32'h0F000F00, 0, 0, 0);
        op_chk("or",       32'hFF00FF00, 32'h0FF00FF0, 4'b0001, 32'hFFF0FFF0, 0, 0, 0);
        op_chk("add_wrap", 32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1, 1, 0);
        op_chk("sub_neg",  32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 0, 0, 0);
        op_chk("slt_pos",  32'h00000003, 32'h00000005, 4'b0111, 32'h00000001, 0, 0, 0);
        op_chk("unsup",    32'h12345678, 32'h0000FFFF, 4'b0011, 32'h00000000, 1, 0, 0);

        // Mid-run start pulse and operand change must be ignored.
        @(negedge clk);
        src1 = 32'd3; src2 = 32'd4; ALU_control = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                start = 1'b1; src1 = 32'd100; ALU_control = 4'b0000;
            end else if (i == 11) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                chk("midrun.res", result, 32'd7);
                chk("midrun.lat", i + 1, 33);
            end
        end
        chk("midrun.dones", dones, 1);
        chk("midrun.busy", {31'd0, busy}, 32'd0);

        // Start held high re-triggers on the first IDLE cycle after FIN.
        do_op(32'd10, 32'd20, 4'b0010, 1'b1, cyc);
        chk("hold.res", result, 32'd30);
        @(posedge clk); #1;
        chk("hold.idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("hold.retrig_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold.res2", result, 32'd30);
        @(posedge clk); #1;

        // Reset during RUN aborts without a done pulse.
        @(negedge clk);
        src1 = 32'd1; src2 = 32'd2; ALU_control = 4'b0010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.res", result, 32'd0);
        chk("abort.zero", {31'd0, zero}, 32'd1);
        chk("abort.done", {31'd0, done}, 32'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort.nodone", dones, 0);
        op_chk("after_abort", 32'h00001000, 32'h00000234, 4'b0010, 32'h00001234, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
